// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Word-organised data memory that answers a single-outstanding request/response
// handshake. A request is accepted in IDLE. The responder then waits a fixed
// number of cycles and presents one response, which it holds until the
// initiator takes it.
//
// Optional feature (macro DMEM_ERR_EN):
//   When defined, misaligned or out-of-range byte addresses are rejected with
//   rsp_err = 1. The write is suppressed and rsp_rdata = 0. Response timing
//   does not change.
//   When undefined, rsp_err is tied low, addr[1:0] is ignored and the word
//   index wraps modulo DEPTH_WORDS.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit storage words (power of two, 2..2^29)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    synchronous reset, ACTIVE-HIGH despite the name
//   req_valid  request present                 req_ready  responder idle
//   req_we     1 = write, 0 = read             req_addr   byte address
//   req_wdata  write data                      req_be     write byte enables
//   rsp_valid  response present                rsp_ready  initiator takes it
//   rsp_rdata  read data (0 for writes/errors) rsp_err    request rejected
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
  // Counter value on the last WAIT cycle; the WAIT state runs WAIT_CYCLES cycles.
  localparam logic [3:0]  WAIT_LAST = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  wait_cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  // Captured request (data path, not reset)
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic accept;
  assign accept = req_valid && req_ready_q;

  // With zero wait states the commit happens on the accepting edge itself, so
  // the operands come straight from the request ports instead of the capture
  // registers.
  logic          cmt_we;
  logic [31:0]   cmt_addr;
  logic [31:0]   cmt_wdata;
  logic [3:0]    cmt_be;
  logic [AW-1:0] cmt_idx;
  logic          cmt_err;

  assign cmt_we    = ZERO_WAIT ? req_we    : we_q;
  assign cmt_addr  = ZERO_WAIT ? req_addr  : addr_q;
  assign cmt_wdata = ZERO_WAIT ? req_wdata : wdata_q;
  assign cmt_be    = ZERO_WAIT ? req_be    : be_q;
  assign cmt_idx   = cmt_addr[AW+1:2];

`ifdef DMEM_ERR_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  assign cmt_err = (cmt_addr[1:0] != 2'b00) || ({1'b0, cmt_addr} >= ADDR_LIMIT);
`else
  assign cmt_err = 1'b0;
  // Byte-offset and above-range address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cmt_addr[31:AW+2], cmt_addr[1:0]};
`endif

  // Commit edge: leaving WAIT, or leaving IDLE directly when there are no wait
  // states. Reset on that edge aborts the request, so its write is dropped.
  logic commit;
  logic wr_en;
  logic [31:0] rd_word;

  assign commit  = !reset_n &&
                   (ZERO_WAIT ? accept
                              : (state_q == ST_WAIT) && (wait_cnt_q == WAIT_LAST));
  assign wr_en   = commit && cmt_we && !cmt_err;
  assign rd_word = (cmt_we || cmt_err) ? 32'd0 : mem_q[cmt_idx];

  // Request capture
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Storage: byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (cmt_be[i]) begin
          mem_q[cmt_idx][8*i +: 8] <= cmt_wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            wait_cnt_q  <= 4'd0;
            if (ZERO_WAIT) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rd_word;
              rsp_err_q   <= cmt_err;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rd_word;
            rsp_err_q   <= cmt_err;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
